fw_action_engine: RTL and testbench
===================================

# fw_action_engine

Enforcement stage directly downstream of the firewall pattern checker: consumes its per-cycle violation flags together with the data stream, aligns the two, and decides per word whether to forward, forward-with-alert, or drop. A strike counter and a four-state enforcement FSM (PASS/ALERT/BLOCK/COOLDOWN) turn isolated hits into timed blocking windows. Output feeds the egress port / logging path.

## Interface
- ALIGN_DELAY, 2: cycles data is delayed to line up with `pattern_violation` (1..7)
- STRIKE_LIMIT, 3: strikes that escalate to BLOCK (1..15)
- ALERT_WINDOW, 8: clean cycles in ALERT before stepping back to PASS
- BLOCK_CYCLES, 16: length of a BLOCK window in cycles
- COOLDOWN_CYCLES, 32: clean cycles in COOLDOWN before returning to PASS
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- data_in  in  32  word presented to the pattern checker this cycle
- data_valid  in  1  data_in qualifier
- pattern_violation  in  1  combined violation flag from the checker
- signature_flag  in  1  known-signature flag from the checker (severe)
- data_out  out  32  forwarded word
- data_out_valid  out  1  data_out qualifier; never high for a dropped word
- drop  out  1  pulse: aligned valid word was discarded
- alert  out  1  high in ALERT and COOLDOWN
- block_active  out  1  high in BLOCK
- strike_count  out  4  current strikes, saturating at 15
- fsm_state  out  2  PASS=0, ALERT=1, BLOCK=2, COOLDOWN=3
- drop_total  out  16  dropped-word count (see Configuration)
- block_events  out  8  BLOCK entries (see Configuration)

## Operation
- Delay line: ALIGN_DELAY-deep shift register of {data_valid, data_in}; tail word `aw`/`av` is the word the current `pattern_violation` refers to.
- A "hit" = `pattern_violation` high this cycle (sampled every cycle, independent of valid). "Severe" = hit with `signature_flag` high.
- PASS: severe -> BLOCK; hit -> strikes+1, to BLOCK if strikes+1 ≥ STRIKE_LIMIT else ALERT.
- ALERT: window counter counts clean cycles; hit -> strikes+1, window restarts, escalate as in PASS; counter reaches ALERT_WINDOW -> PASS, strikes−1 (floor 0).
- BLOCK: counter runs BLOCK_CYCLES; any hit restarts it; expiry -> COOLDOWN, block counter cleared.
- COOLDOWN: any hit -> BLOCK; COOLDOWN_CYCLES clean cycles -> PASS, strikes cleared to 0.
- Entering BLOCK clears strikes to 0 and increments block_events.
- Drop rule: aligned valid word dropped if current state is BLOCK or this cycle's transition is into BLOCK (same-cycle kill). Otherwise forwarded.
- strike_count saturates at 15; counters for windows sized by $clog2 of their parameter + 1.

## Timing
- Reset (sync, rst high at clk edge): fsm_state=PASS, strikes=0, all counters 0, delay line cleared, data_out=0, data_out_valid=0, drop=0, alert=0, block_active=0, drop_total=0, block_events=0.
- Reset mid-BLOCK: next cycle PASS, in-flight words discarded (not counted as drops).
- Latency data_in -> data_out: ALIGN_DELAY+1 cycles; outputs registered.
- drop, alert, block_active, fsm_state registered, same cycle as the corresponding data_out slot.
- Hit and window expiry in same cycle: hit wins.
- No back-pressure; one word per cycle sustained.

## Configuration
- FW_ACTION_STATS_EN defined: drop_total (16-bit, saturating at 0xFFFF) increments per drop pulse; block_events (8-bit, saturating) increments per BLOCK entry.
- Undefined: counters not built; drop_total and block_events tied to 0. FSM/drop behaviour identical.

## Structure
- Shared package `fw_pkg`: state enum (PASS/ALERT/BLOCK/COOLDOWN, 2-bit), default parameter constants, stats widths.
- One sub-module `fw_align_delay` (parameterised depth/width shift register with synchronous clear); FSM and counters stay in top.

## Test plan
- Clean stream 0x1..0x20, no hits -> words appear 3 cycles later unchanged, fsm_state=0, drop never high.
- One hit pulse -> ALERT, strike_count=1, alert=1; 8 clean cycles later -> PASS, strike_count=0.
- Three hits spaced 2 cycles -> third hit enters BLOCK, its aligned word dropped, block_active=1 for 16 cycles, strike_count=0, block_events=1.
- severe hit (signature_flag=1) from PASS -> immediate BLOCK; hit at BLOCK cycle 10 restarts window (BLOCK lasts 26 cycles total).
- Hit during COOLDOWN -> straight back to BLOCK; 32 clean COOLDOWN cycles -> PASS.
- rst asserted mid-BLOCK -> next cycle all outputs at reset values, data_out_valid=0 until new words traverse delay.

Source files
------------

// File: rtl/fw_pkg.sv
// fw_pkg: shared state encoding, default parameters and stats widths for the firewall action engine
package fw_pkg;
  typedef enum logic [1:0] {PASS = 2'd0, ALERT = 2'd1, BLOCK = 2'd2, COOLDOWN = 2'd3} fw_state_e;
  localparam int DATA_W = 32;
  localparam int DEF_ALIGN_DELAY = 2;
  localparam int DEF_STRIKE_LIMIT = 3;
  localparam int DEF_ALERT_WINDOW = 8;
  localparam int DEF_BLOCK_CYCLES = 16;
  localparam int DEF_COOLDOWN_CYCLES = 32;
  localparam int DROP_TOTAL_W = 16;
  localparam int BLOCK_EVENTS_W = 8;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/fw_action_engine_if.sv
// fw_action_engine_if: checker-side inputs and egress/status outputs of the action engine
interface fw_action_engine_if;
  import fw_pkg::*;
  logic [DATA_W-1:0] data_in;
  logic data_valid;
  logic pattern_violation;
  logic signature_flag;
  logic [DATA_W-1:0] data_out;
  logic data_out_valid;
  logic drop;
  logic alert;
  logic block_active;
  logic [3:0] strike_count;
  logic [1:0] fsm_state;
  logic [DROP_TOTAL_W-1:0] drop_total;
  logic [BLOCK_EVENTS_W-1:0] block_events;
  modport master (
    output data_in, data_valid, pattern_violation, signature_flag,
    input data_out, data_out_valid, drop, alert, block_active, strike_count, fsm_state, drop_total, block_events
  );
  modport slave (
    input data_in, data_valid, pattern_violation, signature_flag,
    output data_out, data_out_valid, drop, alert, block_active, strike_count, fsm_state, drop_total, block_events
  );
endinterface

// File: rtl/fw_align_delay.sv
// fw_align_delay: DEPTH-stage shift register with synchronous clear
module fw_align_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic clk,
  input  logic clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
  // shift in at index 0; the oldest stage falls off the top
  always_comb sr_d = (DEPTH*WIDTH)'({sr_q, d});
  always_ff @(posedge clk) begin
    if (clr) sr_q <= '0;
    else sr_q <= sr_d;
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/fw_action_engine.sv
// fw_action_engine: aligns data with violation flags and forwards/alerts/drops via a strike-driven PASS/ALERT/BLOCK/COOLDOWN FSM
// Define FW_ACTION_STATS_EN to build the drop_total/block_events counters.
module fw_action_engine
  import fw_pkg::*;
#(
  parameter int ALIGN_DELAY = DEF_ALIGN_DELAY,
  parameter int STRIKE_LIMIT = DEF_STRIKE_LIMIT,
  parameter int ALERT_WINDOW = DEF_ALERT_WINDOW,
  parameter int BLOCK_CYCLES = DEF_BLOCK_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input logic clk,
  input logic rst,
  fw_action_engine_if.slave io
);
  localparam int CW = cnt_w(ALERT_WINDOW, BLOCK_CYCLES, COOLDOWN_CYCLES);
  fw_state_e state_q, state_d;
  logic [3:0] strikes_q, strikes_d, strike_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] aw, data_out_q, data_out_d;
  logic av, hit, esc, entry, kill;
  logic dv_q, dv_d, drop_q, drop_d, alert_q, alert_d, blk_q, blk_d;
  fw_align_delay #(.DEPTH(ALIGN_DELAY), .WIDTH(DATA_W + 1)) u_align (
    .clk(clk),
    .clr(rst),
    .d({io.data_valid, io.data_in}),
    .q({av, aw})
  );
  // one shared counter: each state times only its own window
  always_comb begin
    hit = io.pattern_violation;
    strike_inc = (strikes_q == 4'hF) ? 4'hF : strikes_q + 4'd1;
    esc = io.signature_flag || ({1'b0, strikes_q} + 5'd1 >= 5'(STRIKE_LIMIT));
    state_d = state_q;
    strikes_d = strikes_q;
    cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      PASS, ALERT:
        if (hit) begin
          state_d = esc ? BLOCK : ALERT;
          strikes_d = strike_inc;
          cnt_d = '0;
        end else if (state_q == PASS) cnt_d = '0;
        else if (cnt_q == CW'(ALERT_WINDOW - 1)) begin
          state_d = PASS;
          strikes_d = (strikes_q == 4'd0) ? 4'd0 : strikes_q - 4'd1;
          cnt_d = '0;
        end
      BLOCK:
        if (hit) cnt_d = '0;
        else if (cnt_q == CW'(BLOCK_CYCLES - 1)) begin
          state_d = COOLDOWN;
          cnt_d = '0;
        end
      COOLDOWN:
        if (hit) begin
          state_d = BLOCK;
          cnt_d = '0;
        end else if (cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
          state_d = PASS;
          strikes_d = '0;
          cnt_d = '0;
        end
    endcase
    entry = (state_d == BLOCK) && (state_q != BLOCK);
    if (entry) strikes_d = '0;
    kill = (state_q == BLOCK) || (state_d == BLOCK);
    dv_d = av && !kill;
    drop_d = av && kill;
    data_out_d = dv_d ? aw : '0;
    alert_d = (state_d == ALERT) || (state_d == COOLDOWN);
    blk_d = state_d == BLOCK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      strikes_q <= '0;
      cnt_q <= '0;
      data_out_q <= '0;
      dv_q <= 1'b0;
      drop_q <= 1'b0;
      alert_q <= 1'b0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      strikes_q <= strikes_d;
      cnt_q <= cnt_d;
      data_out_q <= data_out_d;
      dv_q <= dv_d;
      drop_q <= drop_d;
      alert_q <= alert_d;
      blk_q <= blk_d;
    end
  end
  assign io.data_out = data_out_q;
  assign io.data_out_valid = dv_q;
  assign io.drop = drop_q;
  assign io.alert = alert_q;
  assign io.block_active = blk_q;
  assign io.strike_count = strikes_q;
  assign io.fsm_state = state_q;
`ifdef FW_ACTION_STATS_EN
  logic [DROP_TOTAL_W-1:0] drop_total_q, drop_total_d;
  logic [BLOCK_EVENTS_W-1:0] block_events_q, block_events_d;
  always_comb begin
    drop_total_d = (drop_d && drop_total_q != '1) ? drop_total_q + 1'b1 : drop_total_q;
    block_events_d = (entry && block_events_q != '1) ? block_events_q + 1'b1 : block_events_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_total_q <= '0;
      block_events_q <= '0;
    end else begin
      drop_total_q <= drop_total_d;
      block_events_q <= block_events_d;
    end
  end
  assign io.drop_total = drop_total_q;
  assign io.block_events = block_events_q;
`else
  assign io.drop_total = '0;
  assign io.block_events = '0;
`endif
endmodule

// File: tb/tb_fw_action_engine.sv
// tb_fw_action_engine: randomized self-checking bench against a timer-based behavioural model
module tb_fw_action_engine;
  import fw_pkg::*;
  localparam int AD = 2, SL = 3, AWN = 8, BC = 16, CD = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fw_action_engine_if io();
  fw_action_engine #(
    .ALIGN_DELAY(AD), .STRIKE_LIMIT(SL), .ALERT_WINDOW(AWN),
    .BLOCK_CYCLES(BC), .COOLDOWN_CYCLES(CD)
  ) dut (.clk(clk), .rst(rst), .io(io));
  int checks = 0, passed = 0;
  int m_mode, m_strikes, m_left, m_drops, m_events;
  logic [32:0] m_q[$];
  logic [65:0] exp_v;
  wire [65:0] act_v = {io.data_out_valid ? io.data_out : 32'h0, io.data_out_valid, io.drop, io.alert,
                       io.block_active, io.strike_count, io.fsm_state, io.drop_total, io.block_events};
`ifdef FW_ACTION_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  task automatic model_reset();
    m_mode = 0; m_strikes = 0; m_left = 0; m_drops = 0; m_events = 0;
    m_q.delete();
    for (int i = 0; i < AD; i++) m_q.push_back(33'h0);
    exp_v = '0;
  endtask
  task automatic enter_block();
    m_mode = 2; m_left = BC; m_strikes = 0;
    if (STATS == 1 && m_events < 255) m_events++;
  endtask
  // mode 0..3 = PASS/ALERT/BLOCK/COOLDOWN; m_left = cycles remaining in the current window
  task automatic model_step(input logic v, input logic [31:0] d, input logic pv, input logic sf);
    logic [32:0] a;
    int prev;
    bit kill, av;
    a = m_q.pop_front();
    m_q.push_back({v, d});
    prev = m_mode;
    case (m_mode)
      0, 1:
        if (pv) begin
          if (sf || m_strikes + 1 >= SL) enter_block();
          else begin m_mode = 1; m_strikes = (m_strikes < 15) ? m_strikes + 1 : 15; m_left = AWN; end
        end else if (m_mode == 1) begin
          m_left--;
          if (m_left == 0) begin m_mode = 0; if (m_strikes > 0) m_strikes--; end
        end
      2:
        if (pv) m_left = BC;
        else begin m_left--; if (m_left == 0) begin m_mode = 3; m_left = CD; end end
      default:
        if (pv) enter_block();
        else begin m_left--; if (m_left == 0) begin m_mode = 0; m_strikes = 0; end end
    endcase
    kill = (prev == 2) || (m_mode == 2);
    av = a[32];
    if (STATS == 1 && av && kill && m_drops < 65535) m_drops++;
    exp_v = {(av && !kill) ? a[31:0] : 32'h0, av && !kill, av && kill, m_mode == 1 || m_mode == 3,
             m_mode == 2, 4'(m_strikes), 2'(m_mode), 16'(m_drops), 8'(m_events)};
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic pv, input logic sf);
    io.data_valid = v; io.data_in = d; io.pattern_violation = pv; io.signature_flag = sf;
    model_step(v, d, pv, sf);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    io.data_valid = 1'b1; io.data_in = $urandom; io.pattern_violation = 1'b1; io.signature_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (act_v !== 66'h0) $display("FAIL reset: got %h expected 0", act_v); else passed++;
  endtask
  task automatic test_clean_stream();
    do_reset();
    for (int i = 1; i <= 32 + AD + 1; i++) begin
      step(i <= 32, 32'(i), 1'b0, 1'b0);
      checks++;
      if (act_v !== exp_v) $display("FAIL clean cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
      if (i > AD && i <= 32 + AD) begin
        checks++;
        if (io.data_out !== 32'(i - AD) || io.data_out_valid !== 1'b1 || io.drop !== 1'b0 || io.fsm_state !== 2'd0)
          $display("FAIL clean_word cyc%0d: got %h/%b expected %h/1", i, io.data_out, io.data_out_valid, i - AD);
        else passed++;
      end
    end
  endtask
  task automatic test_single_hit();
    do_reset();
    step(1'b1, $urandom, 1'b1, 1'b0);
    checks++;
    if (io.fsm_state !== 2'd1 || io.strike_count !== 4'd1 || io.alert !== 1'b1)
      $display("FAIL hit_alert: got st=%0d sc=%0d al=%b expected 1/1/1", io.fsm_state, io.strike_count, io.alert);
    else passed++;
    for (int i = 1; i <= AWN; i++) begin
      step(1'($urandom), $urandom, 1'b0, 1'b0);
      checks++;
      if (act_v !== exp_v) $display("FAIL alert_win cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
    end
    checks++;
    if (io.fsm_state !== 2'd0 || io.strike_count !== 4'd0 || io.alert !== 1'b0)
      $display("FAIL alert_expire: got st=%0d sc=%0d expected 0/0", io.fsm_state, io.strike_count);
    else passed++;
  endtask
  task automatic test_three_hits();
    int blk;
    do_reset();
    for (int i = 0; i < AD; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, i % 2 == 0, 1'b0);
    checks++;
    if (io.drop !== 1'b1 || io.data_out_valid !== 1'b0 || io.fsm_state !== 2'd2 || io.strike_count !== 4'd0 ||
        io.block_events !== 8'(STATS))
      $display("FAIL third_hit: got drop=%b dv=%b st=%0d sc=%0d ev=%0d expected 1/0/2/0/%0d",
               io.drop, io.data_out_valid, io.fsm_state, io.strike_count, io.block_events, STATS);
    else passed++;
    blk = 1;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      blk += io.block_active;
      checks++;
      if (act_v !== exp_v) $display("FAIL block_win cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
    end
    checks++;
    if (blk !== BC) $display("FAIL block_len: got %0d expected %0d", blk, BC); else passed++;
  endtask
  task automatic test_severe_restart();
    int blk;
    do_reset();
    step(1'b1, $urandom, 1'b1, 1'b1);
    blk = io.block_active;
    for (int i = 1; i <= 40; i++) begin
      step(1'($urandom), $urandom, i == 10, 1'b0);
      blk += io.block_active;
      checks++;
      if (act_v !== exp_v) $display("FAIL severe cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
    end
    checks++;
    if (blk !== 26) $display("FAIL severe_len: got %0d expected 26", blk); else passed++;
  endtask
  task automatic test_cooldown();
    checks++;
    if (io.fsm_state !== 2'd3) $display("FAIL cooldown_entry: got %0d expected 3", io.fsm_state); else passed++;
    step(1'b1, $urandom, 1'b1, 1'b0);
    checks++;
    if (io.fsm_state !== 2'd2 || io.block_active !== 1'b1)
      $display("FAIL cooldown_hit: got %0d expected 2", io.fsm_state);
    else passed++;
    for (int i = 1; i <= BC + CD; i++) begin
      step(1'($urandom), $urandom, 1'b0, 1'b0);
      checks++;
      if (act_v !== exp_v) $display("FAIL cooldown cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
      if (i == BC + CD - 1) begin
        checks++;
        if (io.fsm_state !== 2'd3) $display("FAIL cooldown_late: got %0d expected 3", io.fsm_state); else passed++;
      end
    end
    checks++;
    if (io.fsm_state !== 2'd0 || io.alert !== 1'b0) $display("FAIL cooldown_exit: got %0d expected 0", io.fsm_state);
    else passed++;
  endtask
  task automatic test_reset_mid_block();
    do_reset();
    step(1'b1, $urandom, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (act_v !== 66'h0) $display("FAIL mid_reset: got %h expected 0", act_v); else passed++;
    for (int i = 1; i <= AD + 2; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      checks++;
      if (io.data_out_valid !== (i > AD) || act_v !== exp_v)
        $display("FAIL mid_reset_refill cyc%0d: got %h expected %h", i, act_v, exp_v);
      else passed++;
    end
  endtask
  task automatic test_random();
    logic pv;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pv = $urandom_range(0, 9) == 0;
      step($urandom_range(0, 3) != 0, $urandom, pv, pv && $urandom_range(0, 4) == 0);
      checks++;
      if (act_v !== exp_v) $display("FAIL random cyc%0d: got %h expected %h", i, act_v, exp_v); else passed++;
    end
  endtask
  initial begin
    rst = 1'b1;
    io.data_valid = 1'b0; io.data_in = '0; io.pattern_violation = 1'b0; io.signature_flag = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_stream();
    test_single_hit();
    test_three_hits();
    test_severe_restart();
    test_cooldown();
    test_reset_mid_block();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
